control_sequencer: RTL

//  Fetch/decode/execute controller for the 16-bit accumulator computer.

---
 rtl/control_sequencer_pkg.sv | 63 ++++++
 rtl/control_sequencer_if.sv | 36 +++
 rtl/control_sequencer_skip_cond_eval.sv | 23 ++
 rtl/control_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// control_pkg: shared encodings for the accumulator-machine sequencer.
// Opcodes, state codes, mux selects, skip conditions and ALU operations.
package control_pkg;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_LOAD     = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD      = 4'h3;
    localparam logic [3:0] OP_SUB      = 4'h4;
    localparam logic [3:0] OP_AND      = 4'h5;
    localparam logic [3:0] OP_OR       = 4'h6;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_SKIPCOND = 4'h8;
    localparam logic [3:0] OP_JUMP     = 4'h9;
    localparam logic [3:0] OP_CLEAR    = 4'hA;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_F_ADDR  = 4'd1,
        S_F_WAIT  = 4'd2,
        S_F_LOAD  = 4'd3,
        S_DECODE  = 4'd4,
        S_E_WAIT  = 4'd5,
        S_E_MBR   = 4'd6,
        S_E_ACC   = 4'd7,
        S_E_STORE = 4'd8,
        S_HALTED  = 4'd9
    } state_t;

    localparam logic       PC_SEL_INC   = 1'b0;
    localparam logic       PC_SEL_IR    = 1'b1;
    localparam logic       MAR_SEL_PC   = 1'b0;
    localparam logic       MAR_SEL_IR   = 1'b1;
    localparam logic [1:0] ACC_SEL_ALU  = 2'b00;
    localparam logic [1:0] ACC_SEL_MBR  = 2'b01;
    localparam logic [1:0] ACC_SEL_ZERO = 2'b10;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;

    localparam logic [1:0] COND_NEG   = 2'b00;
    localparam logic [1:0] COND_ZERO  = 2'b01;
    localparam logic [1:0] COND_POS   = 2'b10;
    localparam logic [1:0] COND_NEVER = 2'b11;

    // Opcodes that read a memory operand into MBR before touching ACC.
    function automatic logic needs_operand(input logic [3:0] op);
        needs_operand = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB)
                     || (op == OP_AND)  || (op == OP_OR);
    endfunction

    function automatic logic [3:0] alu_map(input logic [3:0] op);
        case (op)
            OP_SUB:  alu_map = ALU_SUB;
            OP_AND:  alu_map = ALU_AND;
            OP_OR:   alu_map = ALU_OR;
            default: alu_map = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: sequencer <-> datapath control bundle.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
    logic       start;
    logic [3:0] ir_opcode;
    logic [1:0] ir_cond;
    logic       acc_neg;
    logic       acc_zero;
    logic       pc_write;
    logic       pc_sel;
    logic       mar_write;
    logic       mar_sel;
    logic       ir_write;
    logic       mbr_write;
    logic       acc_write;
    logic [1:0] acc_sel;
    logic [3:0] alu_opcode;
    logic       mem_write_enable;
    logic       halted;
    logic       illegal;
    logic [3:0] state_dbg;

    modport master (
        input  start, ir_opcode, ir_cond, acc_neg, acc_zero,
        output pc_write, pc_sel, mar_write, mar_sel, ir_write,
        output mbr_write, acc_write, acc_sel, alu_opcode,
        output mem_write_enable, halted, illegal, state_dbg
    );

    modport slave (
        output start, ir_opcode, ir_cond, acc_neg, acc_zero,
        input  pc_write, pc_sel, mar_write, mar_sel, ir_write,
        input  mbr_write, acc_write, acc_sel, alu_opcode,
        input  mem_write_enable, halted, illegal, state_dbg
    );
endinterface

// File: rtl/control_sequencer_skip_cond_eval.sv
// skip_cond_eval: SKIPCOND predicate on the ACC sign/zero flags.
// Condition 11 never skips.
module skip_cond_eval
    import control_pkg::*;
(
    input  logic [1:0] ir_cond_i,
    input  logic       acc_neg_i,
    input  logic       acc_zero_i,
    output logic       skip_o
);

    // Select the flag combination named by the condition field.
    always_comb begin
        skip_o = 1'b0;
        unique case (ir_cond_i)
            COND_NEG:  skip_o = acc_neg_i;
            COND_ZERO: skip_o = acc_zero_i;
            COND_POS:  skip_o = !acc_neg_i && !acc_zero_i;
            default:   skip_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute controller for the
// 16-bit accumulator computer; sequences an external datapath.
module control_sequencer
    import control_pkg::*;
#(
    parameter int MEM_READ_LATENCY = 1,
    parameter int ADDR_WIDTH       = 12
) (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.master bus
);

    if (MEM_READ_LATENCY < 1 || ADDR_WIDTH < 2) begin : g_bad_param
        $error("control_sequencer: MEM_READ_LATENCY>=1, ADDR_WIDTH>=2");
    end

    localparam int WCW = (MEM_READ_LATENCY > 1) ? $clog2(MEM_READ_LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_INIT = WCW'(MEM_READ_LATENCY - 1);

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           halted_q, halted_d;
    logic           illegal_q, illegal_d;
    logic           skip;
    logic [3:0]     op;

    logic       pc_write, pc_sel, mar_write, mar_sel;
    logic       ir_write, mbr_write, acc_write, mem_we;
    logic [1:0] acc_sel;
    logic [3:0] alu_opcode;

    assign op = bus.ir_opcode;

    skip_cond_eval u_skip (
        .ir_cond_i  (bus.ir_cond),
        .acc_neg_i  (bus.acc_neg),
        .acc_zero_i (bus.acc_zero),
        .skip_o     (skip)
    );

    // Next state, wait countdown and sticky halt/illegal flags.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_F_ADDR;
            S_F_ADDR: begin
                state_d = S_F_WAIT;
                wait_d  = WAIT_INIT;
            end
            S_F_WAIT: begin
                if (wait_q == '0) state_d = S_F_LOAD;
                else              wait_d  = wait_q - 1'b1;
            end
            S_F_LOAD: state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_F_ADDR;
                unique case (1'b1)
                    needs_operand(op): begin
                        state_d = S_E_WAIT;
                        wait_d  = WAIT_INIT;
                    end
                    op == OP_STORE: state_d = S_E_STORE;
                    op == OP_HALT: begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end
                    op > OP_CLEAR: begin
                        state_d   = S_HALTED;
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E_WAIT: begin
                if (wait_q == '0) state_d = S_E_MBR;
                else              wait_d  = wait_q - 1'b1;
            end
            S_E_MBR:   state_d = S_E_ACC;
            S_E_ACC:   state_d = S_F_ADDR;
            S_E_STORE: state_d = S_F_ADDR;
            S_HALTED:  state_d = S_HALTED;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // Datapath enables decoded from state (plus IR/ACC flags in DECODE).
    always_comb begin
        pc_write   = 1'b0;
        pc_sel     = PC_SEL_INC;
        mar_write  = 1'b0;
        mar_sel    = MAR_SEL_PC;
        ir_write   = 1'b0;
        mbr_write  = 1'b0;
        acc_write  = 1'b0;
        acc_sel    = ACC_SEL_ALU;
        alu_opcode = ALU_ADD;
        mem_we     = 1'b0;
        unique case (state_q)
            S_F_ADDR: mar_write = 1'b1;
            S_F_LOAD: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                unique case (1'b1)
                    op == OP_CLEAR: begin
                        acc_write = 1'b1;
                        acc_sel   = ACC_SEL_ZERO;
                    end
                    op == OP_JUMP: begin
                        pc_write = 1'b1;
                        pc_sel   = PC_SEL_IR;
                    end
                    op == OP_SKIPCOND: pc_write = skip;
                    needs_operand(op) || op == OP_STORE: begin
                        mar_write = 1'b1;
                        mar_sel   = MAR_SEL_IR;
                    end
                    default: ;
                endcase
            end
            S_E_MBR: mbr_write = 1'b1;
            S_E_ACC: begin
                acc_write  = 1'b1;
                acc_sel    = (op == OP_LOAD) ? ACC_SEL_MBR : ACC_SEL_ALU;
                alu_opcode = (op == OP_LOAD) ? ALU_ADD : alu_map(op);
            end
            S_E_STORE: mem_we = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_write         = pc_write;
    assign bus.pc_sel           = pc_sel;
    assign bus.mar_write        = mar_write;
    assign bus.mar_sel          = mar_sel;
    assign bus.ir_write         = ir_write;
    assign bus.mbr_write        = mbr_write;
    assign bus.acc_write        = acc_write;
    assign bus.acc_sel          = acc_sel;
    assign bus.alu_opcode       = alu_opcode;
    assign bus.mem_write_enable = mem_we;
    assign bus.halted           = halted_q;
    assign bus.illegal          = illegal_q;
    assign bus.state_dbg        = state_q;

endmodule
